// File: rtl/usb_stream_pkg.sv
// Shared types and helpers for the PC-bound stream scheduler.
// State enum, header magic, command bit indices, header builder.
package usb_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SETTLE,
    ST_ARB,
    ST_HDR,
    ST_PAY
  } state_e;

  localparam logic [3:0] HDR_MAGIC = 4'hA;

  localparam int CMD_START = 0;
  localparam int CMD_ABORT = 1;

  function automatic logic [31:0] hdr_word(
    input logic        src,
    input logic [15:0] seq
  );
    return {HDR_MAGIC, src, 11'b0, seq};
  endfunction

endpackage

// File: rtl/cmd_sync_edge.sv
// Two-flop synchronizer plus rising-edge detect for one command level.
// Ports: clk, reset_n, d_i (async level), rise_o (one-cycle pulse).
module cmd_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic rise_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q <= 3'b000;
    end else begin
      sh_q <= {sh_q[1:0], d_i};
    end
  end

  assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/usb_stream_sched.sv
// Block-granular write scheduler for the shared PC-bound FIFO.
// Ports: pc_command start/abort, src0/src1 valid-ready, FIFO write side, status.
module usb_stream_sched
  import usb_stream_pkg::*;
#(
  parameter int          BLOCK_WORDS = 256,
  parameter int          TIMEOUT     = 1024,
  parameter logic [31:0] PAD_WORD    = 32'h0000_0000,
  parameter int          RST_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_command,
  input  logic        s0_valid,
  input  logic [31:0] s0_data,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [31:0] s1_data,
  output logic        s1_ready,
  input  logic        fifo_full,
  input  logic        fifo_prog_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_din,
  output logic        fifo_wr_rst,
  output logic        busy,
  output logic [15:0] blk_count,
  output logic [15:0] pad_count
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [15:0] PAY_LAST = 16'(BLOCK_WORDS - 2);
  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  logic start_rise;
  logic abort_rise;
  logic unused_cmd;

  assign unused_cmd = ^pc_command[31:2];

  cmd_sync_edge u_start (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (pc_command[CMD_START]),
    .rise_o (start_rise)
  );

  cmd_sync_edge u_abort (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (pc_command[CMD_ABORT]),
    .rise_o (abort_rise)
  );

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          src_q, src_d;
  logic          last_q, last_d;
  logic          abt_q, abt_d;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   blk_q, blk_d;
  logic [15:0]   pad_q, pad_d;
  logic          wr_q, wr_d;
  logic [31:0]   din_q, din_d;

  logic          sel_valid;
  logic [31:0]   sel_data;
  logic          take;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    src_d    = src_q;
    last_d   = last_q;
    abt_d    = abt_q;
    seq_d    = seq_q;
    blk_d    = blk_q;
    pad_d    = pad_q;
    wr_d     = 1'b0;
    din_d    = din_q;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    take     = 1'b0;
    sel_valid = src_q ? s1_valid : s0_valid;
    sel_data  = src_q ? s1_data : s0_data;

    // Abort preempts everything; ready stays low so
    // the word on the bus this cycle is not taken.
    if (abort_rise && state_q != ST_IDLE) begin
      state_d = ST_FLUSH;
      cnt_d   = '0;
      abt_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_rise && !abort_rise) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
            abt_d   = 1'b0;
            seq_d   = '0;
            blk_d   = '0;
            pad_d   = '0;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == RST_LAST) begin
            cnt_d   = '0;
            state_d = abt_q ? ST_IDLE : ST_SETTLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == RST_LAST) begin
            cnt_d   = '0;
            state_d = ST_ARB;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_ARB: begin
          if (!fifo_prog_full && (s0_valid || s1_valid)) begin
            src_d   = (s0_valid && s1_valid) ? !last_q : s1_valid;
            state_d = ST_HDR;
          end
        end
        ST_HDR: begin
          if (!fifo_full) begin
            wr_d    = 1'b1;
            din_d   = hdr_word(src_q, seq_q);
            cnt_d   = '0;
            idle_d  = '0;
            state_d = ST_PAY;
          end
        end
        ST_PAY: begin
          if (idle_q == IDLE_MAX) begin
            // Source went quiet: fill the block out.
            if (!fifo_full) begin
              wr_d  = 1'b1;
              din_d = PAD_WORD;
              take  = 1'b1;
              if (pad_q != 16'hFFFF) pad_d = pad_q + 16'd1;
            end
          end else begin
            s0_ready = !src_q && !fifo_full;
            s1_ready = src_q && !fifo_full;
            if (sel_valid && !fifo_full) begin
              wr_d   = 1'b1;
              din_d  = sel_data;
              idle_d = '0;
              take   = 1'b1;
            end else if (!sel_valid) begin
              idle_d = idle_q + 1'b1;
            end
          end
          if (take) begin
            if (cnt_q == PAY_LAST) begin
              blk_d   = blk_q + 16'd1;
              seq_d   = seq_q + 16'd1;
              last_d  = src_q;
              state_d = ST_ARB;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;
      abt_q   <= 1'b0;
      seq_q   <= '0;
      blk_q   <= '0;
      pad_q   <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      src_q   <= src_d;
      last_q  <= last_d;
      abt_q   <= abt_d;
      seq_q   <= seq_d;
      blk_q   <= blk_d;
      pad_q   <= pad_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
    end
  end

  assign fifo_wr_en  = wr_q;
  assign fifo_din    = din_q;
  assign fifo_wr_rst = (state_q == ST_FLUSH);
  assign busy        = (state_q != ST_IDLE);
  assign blk_count   = blk_q;
  assign pad_count   = pad_q;

endmodule

// File: tb/tb_usb_stream_sched.sv
// Bench for usb_stream_sched: command table plus scoreboarded
// block streaming, timeout pad, full stall, prog_full and abort.
module tb_usb_stream_sched;

  localparam int          BW  = 4;
  localparam int          TO  = 5;
  localparam int          RC  = 8;
  localparam logic [31:0] PAD = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_command;
  logic        s0_valid, s1_valid;
  logic [31:0] s0_data, s1_data;
  logic        s0_ready, s1_ready;
  logic        fifo_full, fifo_prog_full;
  logic        fifo_wr_en, fifo_wr_rst, busy;
  logic [31:0] fifo_din;
  logic [15:0] blk_count, pad_count;

  usb_stream_sched #(
    .BLOCK_WORDS(BW),
    .TIMEOUT    (TO),
    .PAD_WORD   (PAD),
    .RST_CYCLES (RC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_command    (pc_command),
    .s0_valid      (s0_valid),
    .s0_data       (s0_data),
    .s0_ready      (s0_ready),
    .s1_valid      (s1_valid),
    .s1_data       (s1_data),
    .s1_ready      (s1_ready),
    .fifo_full     (fifo_full),
    .fifo_prog_full(fifo_prog_full),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din),
    .fifo_wr_rst   (fifo_wr_rst),
    .busy          (busy),
    .blk_count     (blk_count),
    .pad_count     (pad_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cmd;
    int         cyc;
    logic       busy;
    logic       rst;
  } cmd_vec_t;

  cmd_vec_t    tbl[5];
  int          vectors;
  int          miscompares;
  logic [31:0] exp_q[$];
  int          s0_left, s1_left;
  logic        full_prev;

  function automatic logic [31:0] hdr(
    input logic s, input logic [15:0] q);
    return {4'hA, s, 11'h000, q};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon();
    if (fifo_wr_en) begin
      chk("wr_guard", {31'b0, fifo_wr_rst | full_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got %h want none",
                 fifo_din);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("fifo_din", fifo_din, e);
      end
    end
  endtask

  task automatic step();
    logic a0, a1;
    @(negedge clk);
    mon();
    a0 = s0_valid & s0_ready;
    a1 = s1_valid & s1_ready;
    full_prev = fifo_full;
    @(posedge clk);
    #1;
    if (a0) begin
      s0_left--;
      s0_data = s0_data + 32'd1;
    end
    if (a1) begin
      s1_left--;
      s1_data = s1_data + 32'd1;
    end
    s0_valid = (s0_left > 0);
    s1_valid = (s1_left > 0);
  endtask

  task automatic src_go(input int s, input int n,
                        input logic [31:0] base);
    if (s == 0) begin
      s0_left  = n;
      s0_data  = base;
      s0_valid = (n > 0);
    end else begin
      s1_left  = n;
      s1_data  = base;
      s1_valid = (n > 0);
    end
  endtask

  task automatic push_blk(input logic s, input logic [15:0] q,
                          input logic [31:0] base);
    exp_q.push_back(hdr(s, q));
    for (int i = 0; i < BW - 1; i++)
      exp_q.push_back(base + 32'(i));
  endtask

  task automatic drain(input string nm, input int budget);
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < budget) begin
      step();
      g++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    pc_command = '0;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    s0_data = '0;
    s1_data = '0;
    s0_left = 0;
    s1_left = 0;
    fifo_full = 1'b0;
    fifo_prog_full = 1'b0;
    full_prev = 1'b0;

    tbl[0] = '{2'b11, 5, 1'b0, 1'b0};
    tbl[1] = '{2'b00, 5, 1'b0, 1'b0};
    tbl[2] = '{2'b01, 5, 1'b1, 1'b1};
    tbl[3] = '{2'b01, 8, 1'b1, 1'b0};
    tbl[4] = '{2'b01, 8, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    chk("rst_wr_rst", {31'b0, fifo_wr_rst}, 32'd0);
    chk("rst_din", fifo_din, 32'd0);
    chk("rst_blk", {16'b0, blk_count}, 32'd0);
    chk("rst_pad", {16'b0, pad_count}, 32'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      pc_command = {30'b0, tbl[i].cmd};
      repeat (tbl[i].cyc) step();
      chk($sformatf("cmd%0d_busy", i),
          {31'b0, busy}, {31'b0, tbl[i].busy});
      chk($sformatf("cmd%0d_rst", i),
          {31'b0, fifo_wr_rst}, {31'b0, tbl[i].rst});
    end

    push_blk(1'b0, 16'd0, 32'h1000_0000);
    push_blk(1'b0, 16'd1, 32'h1000_0003);
    src_go(0, 6, 32'h1000_0000);
    drain("stream_drain", 100);
    chk("stream_blk", {16'b0, blk_count}, 32'd2);

    push_blk(1'b1, 16'd2, 32'h3000_0000);
    push_blk(1'b0, 16'd3, 32'h2000_0000);
    push_blk(1'b1, 16'd4, 32'h3000_0003);
    push_blk(1'b0, 16'd5, 32'h2000_0003);
    src_go(0, 6, 32'h2000_0000);
    src_go(1, 6, 32'h3000_0000);
    drain("rr_drain", 200);
    chk("rr_blk", {16'b0, blk_count}, 32'd6);

    push_blk(1'b0, 16'd6, 32'h4000_0000);
    src_go(0, 3, 32'h4000_0000);
    for (int g = 0; g < 50 && s0_left == 3; g++) step();
    fifo_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("full_ready", {31'b0, s0_ready}, 32'd0);
      chk("full_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    end
    fifo_full = 1'b0;
    drain("full_drain", 100);
    chk("full_blk", {16'b0, blk_count}, 32'd7);
    chk("full_left", 32'(s0_left), 32'd0);

    exp_q.push_back(hdr(1'b0, 16'd7));
    exp_q.push_back(32'h5000_0000);
    exp_q.push_back(PAD);
    exp_q.push_back(PAD);
    src_go(0, 1, 32'h5000_0000);
    drain("pad_drain", 100);
    chk("pad_count", {16'b0, pad_count}, 32'd2);
    chk("pad_blk", {16'b0, blk_count}, 32'd8);

    fifo_prog_full = 1'b1;
    src_go(1, 3, 32'h6000_0000);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pfull_wr_en", {31'b0, fifo_wr_en}, 32'd0);
      chk("pfull_ready", {31'b0, s1_ready}, 32'd0);
    end
    push_blk(1'b1, 16'd8, 32'h6000_0000);
    fifo_prog_full = 1'b0;
    drain("pfull_drain", 100);
    chk("pfull_blk", {16'b0, blk_count}, 32'd9);

    exp_q.push_back(hdr(1'b0, 16'd9));
    exp_q.push_back(32'h7000_0000);
    exp_q.push_back(32'h7000_0001);
    src_go(0, 2, 32'h7000_0000);
    for (int g = 0; g < 50 && s0_left > 0; g++) step();
    pc_command = 32'd3;
    for (int g = 0; g < 20 && !fifo_wr_rst; g++) step();
    chk("abort_rst_seen", {31'b0, fifo_wr_rst}, 32'd1);
    begin
      int n;
      n = 0;
      while (fifo_wr_rst && n < 50) begin
        n++;
        step();
      end
      chk("abort_rst_cycles", 32'(n), 32'(RC));
    end
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_drain", 32'(exp_q.size()), 32'd0);

    pc_command = 32'd0;
    repeat (4) step();
    pc_command = 32'd1;
    repeat (22) step();
    chk("restart_busy", {31'b0, busy}, 32'd1);
    chk("restart_blk", {16'b0, blk_count}, 32'd0);
    chk("restart_pad", {16'b0, pad_count}, 32'd0);
    push_blk(1'b0, 16'd0, 32'h8000_0000);
    src_go(0, 3, 32'h8000_0000);
    drain("restart_drain", 100);
    chk("restart_blk1", {16'b0, blk_count}, 32'd1);

    repeat (5) step();
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
